// File: rtl/omsp_spm_key_loader_pkg.sv
// Shared protected-module constants: key geometry and loader state encoding.
// Optional SPM_KEY_ZEROIZE_EN enables the ZERO state in omsp_spm_key_loader.
package omsp_spm_key_loader_pkg;

  localparam int SECURITY  = 64;
  localparam int KEY_WORDS = SECURITY / 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ZERO = 2'd2
  } spm_kl_state_e;

endpackage

// File: rtl/omsp_spm_key_if.sv
// Key-derivation handshake plus protected-module array key write port.
// master = loader side, slave = engine/array side.
interface omsp_spm_key_if #(
  parameter int KEY_IDX_SIZE = 2
);

  logic                    kd_valid;
  logic [15:0]             kd_data;
  logic                    kd_ready;
  logic                    write_key;
  logic [KEY_IDX_SIZE-1:0] key_idx;
  logic [15:0]             key_in;

  modport master (
    input  kd_valid,
    input  kd_data,
    output kd_ready,
    output write_key,
    output key_idx,
    output key_in
  );

  modport slave (
    output kd_valid,
    output kd_data,
    input  kd_ready,
    input  write_key,
    input  key_idx,
    input  key_in
  );

endinterface

// File: rtl/omsp_spm_key_loader.sv
// Streams a derived module key into the protected-module array, 16 bits/cycle.
// Define SPM_KEY_ZEROIZE_EN to wipe the key slot on abort.
module omsp_spm_key_loader
  import omsp_spm_key_loader_pkg::*;
#(
  parameter int KEY_IDX_SIZE = 2
) (
  input  logic                 mclk,
  input  logic                 puc_rst,
  input  logic                 start,
  input  logic                 abort,
  omsp_spm_key_if.master       kif,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  localparam logic [KEY_IDX_SIZE-1:0] LAST =
    KEY_IDX_SIZE'(KEY_WORDS - 1);

  spm_kl_state_e           state_q, state_d;
  logic [KEY_IDX_SIZE-1:0] cnt_q, cnt_d;
  logic                    wk_q, wk_d;
  logic [KEY_IDX_SIZE-1:0] idx_q, idx_d;
  logic [15:0]             kin_q, kin_d;
  logic                    done_q, done_d;
  logic                    ab_q, ab_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wk_d    = 1'b0;
    idx_d   = idx_q;
    kin_d   = kin_q;
    done_d  = 1'b0;
    ab_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (abort) begin
`ifdef SPM_KEY_ZEROIZE_EN
          // first zero write is issued straight from the abort cycle
          state_d = ZERO;
          wk_d    = 1'b1;
          idx_d   = '0;
          kin_d   = 16'h0000;
          cnt_d   = KEY_IDX_SIZE'(1);
`else
          state_d = IDLE;
          ab_d    = 1'b1;
`endif
        end else if (kif.kd_valid) begin
          wk_d  = 1'b1;
          idx_d = cnt_q;
          kin_d = kif.kd_data;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef SPM_KEY_ZEROIZE_EN
      ZERO: begin
        wk_d  = 1'b1;
        idx_d = cnt_q;
        kin_d = 16'h0000;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          ab_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wk_q    <= 1'b0;
      idx_q   <= '0;
      kin_q   <= 16'h0000;
      done_q  <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wk_q    <= wk_d;
      idx_q   <= idx_d;
      kin_q   <= kin_d;
      done_q  <= done_d;
      ab_q    <= ab_d;
    end
  end

  assign kif.kd_ready  = (state_q == LOAD);
  assign kif.write_key = wk_q;
  assign kif.key_idx   = idx_q;
  assign kif.key_in    = kin_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign aborted       = ab_q;

endmodule

// File: tb/tb_omsp_spm_key_loader.sv
// Scoreboard bench for omsp_spm_key_loader (KEY_WORDS=4, KEY_IDX_SIZE=2).
// Honours SPM_KEY_ZEROIZE_EN the same way the design does.
module tb_omsp_spm_key_loader;

  localparam int KW = 4;

  typedef struct packed {
    int          cyc;
    logic        wk;
    logic [1:0]  idx;
    logic [15:0] data;
    logic        dn;
    logic        ab;
  } ev_t;

  logic mclk = 1'b0;
  logic puc_rst;
  logic start, abort, busy, done, aborted;

  omsp_spm_key_if #(.KEY_IDX_SIZE(2)) kif();

  omsp_spm_key_loader #(.KEY_IDX_SIZE(2)) dut (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .start   (start),
    .abort   (abort),
    .kif     (kif.master),
    .busy    (busy),
    .done    (done),
    .aborted (aborted)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  ev_t exp_q[$];

  bit m_load = 0;
  int m_cnt = 0;
  int m_zero_left = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk(nm, {kif.write_key, kif.key_idx, kif.key_in, done, aborted,
             busy, kif.kd_ready}, 64'd0);
  endtask

  // Spec-level model: decides, per sampled input set, which array writes
  // and pulses must appear and in which cycle.
  task automatic step(input bit s, input bit a, input bit v,
                      input logic [15:0] d);
    int ec;
    @(negedge mclk);
    start = s;
    abort = a;
    kif.kd_valid = v;
    kif.kd_data = d;
    chk("kd_ready", 64'(kif.kd_ready), 64'(m_load));
    chk("busy", 64'(busy), 64'(m_load || m_zero_left > 0));
    ec = cyc + 1;
    if (m_zero_left > 0) begin
      m_zero_left--;
    end else if (!m_load) begin
      if (s && !a) begin
        m_load = 1;
        m_cnt = 0;
      end
    end else if (a) begin
      m_load = 0;
`ifdef SPM_KEY_ZEROIZE_EN
      for (int i = 0; i < KW; i++)
        exp_q.push_back('{ec + i, 1'b1, 2'(i), 16'h0, 1'b0, i == KW - 1});
      m_zero_left = KW - 1;
`else
      exp_q.push_back('{ec, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1});
`endif
    end else if (v) begin
      exp_q.push_back('{ec, 1'b1, 2'(m_cnt), d, m_cnt == KW - 1, 1'b0});
      if (m_cnt == KW - 1) m_load = 0;
      m_cnt++;
    end
    @(posedge mclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0);
  endtask

  // Monitor: every output event must match the head of the queue.
  initial begin
    ev_t e, act;
    forever begin
      @(negedge mclk);
      if (!puc_rst && (kif.write_key || done || aborted)) begin
        act = '{cyc, kif.write_key,
                kif.write_key ? kif.key_idx : 2'd0,
                kif.write_key ? kif.key_in : 16'h0, done, aborted};
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(act), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("write_event", 64'(act), 64'(e));
        end
      end
    end
  end

  initial begin
    puc_rst = 1'b1;
    start = 0;
    abort = 0;
    kif.kd_valid = 0;
    kif.kd_data = 16'h0;
    repeat (3) @(negedge mclk);
    chk_quiet("reset_state");
    puc_rst = 1'b0;
    idle(2);

    // basic load, valid held
    step(1, 0, 0, 16'h0);
    step(0, 0, 1, 16'h1111);
    step(0, 0, 1, 16'h2222);
    step(0, 0, 1, 16'h3333);
    step(0, 0, 1, 16'h4444);
    idle(3);

    // back-pressure
    step(1, 0, 0, 16'h0);
    for (int i = 0; i < KW; i++) begin
      step(0, 0, 1, 16'hA000 + 16'(i));
      step(0, 0, 0, 16'hDEAD);
    end
    idle(3);

    // abort after two words
    step(1, 0, 0, 16'h0);
    step(0, 0, 1, 16'h5151);
    step(0, 0, 1, 16'h5252);
    step(0, 1, 1, 16'h5353);
    step(1, 1, 1, 16'h5454);
    idle(KW + 3);

    // start & abort in IDLE
    step(1, 1, 0, 16'h0);
    idle(3);

    // start mid-load
    step(1, 0, 0, 16'h0);
    step(0, 0, 1, 16'h6161);
    step(1, 0, 1, 16'h6262);
    step(1, 0, 1, 16'h6363);
    step(0, 0, 1, 16'h6464);
    idle(3);

    // reset mid-load after one word
    step(1, 0, 0, 16'h0);
    step(0, 0, 1, 16'h7171);
    idle(1);
    @(negedge mclk);
    puc_rst = 1'b1;
    kif.kd_valid = 0;
    #1;
    chk_quiet("reset_mid_load");
    exp_q.delete();
    m_load = 0;
    m_cnt = 0;
    m_zero_left = 0;
    @(negedge mclk);
    puc_rst = 1'b0;
    step(1, 0, 0, 16'h0);
    for (int i = 0; i < KW; i++) step(0, 0, 1, 16'h8000 + 16'(i));
    idle(3);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) != 0, 16'($urandom));
    idle(KW + 4);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/omsp_spm_key_loader.md
# omsp_spm_key_loader

Sequencer that writes a freshly derived module key into the protected-module array, 16 bits per cycle, after a module has been enabled. It takes key words from the key-derivation engine over a valid/ready handshake and drives the array's key write port (`write_key`, `key_idx`, `key_in`). It sits between the key-derivation engine and the protected-module control block, and serves as the writer end of that key write port.

## Interface
- `KEY_IDX_SIZE`, default 2: width of `key_idx`; must satisfy 2^KEY_IDX_SIZE >= KEY_WORDS.
- `KEY_WORDS` (derived, not overridable): `SECURITY`/16, the number of 16-bit key words per module.

Clock and reset are fixed: reset `puc_rst`, asynchronous, active-high; clock `mclk`.

- `mclk`  in  1  clock
- `puc_rst`  in  1  asynchronous active-high reset
- `start`  in  1  single-cycle pulse: module just enabled, key derivation started
- `abort`  in  1  violation or cancel; level-sampled each cycle
- `kd_valid`  in  1  key-derivation engine has a word on `kd_data`
- `kd_data`  in  16  key word, most-significant word first
- `kd_ready`  out  1  loader accepts a word this cycle
- `write_key`  out  1  key write strobe to the array
- `key_idx`  out  KEY_IDX_SIZE  word index of the current write
- `key_in`  out  16  word being written
- `busy`  out  1  state is not IDLE
- `done`  out  1  single-cycle pulse: full key written
- `aborted`  out  1  single-cycle pulse: load terminated by `abort`

## Operation
- **States:** IDLE, LOAD, and ZERO (ZERO exists only with the macro defined).
- **IDLE:**
  - `start` & ~`abort` → LOAD, word counter `cnt` ← 0.
  - `abort` alone in IDLE: no effect, no pulse.
- **LOAD:**
  - `kd_ready` = 1.
  - A transfer is `kd_valid` & `kd_ready`.
  - On a transfer, the word is registered and issued in the next cycle as `write_key`=1, `key_idx`=`cnt`, `key_in`=`kd_data`; then `cnt` ← `cnt`+1.
  - The transfer of word KEY_WORDS-1 → IDLE. Its write cycle also asserts `done`.
  - `kd_valid` low holds the state; the loader has no timeout.
- **`start` while busy:** ignored; the count does not restart.
- **`abort` in LOAD** (takes priority over a same-cycle transfer; that word is dropped and never written):
  - Without the macro: → IDLE, `aborted` pulses the next cycle, no further writes.
  - With the macro: → ZERO (see Configuration).
- **`start` & `abort` in the same cycle in IDLE:** stay IDLE, no pulses.
- **Word indexing:** `cnt` is KEY_IDX_SIZE bits wide and never exceeds KEY_WORDS-1; no wrap is reachable.
- **`write_key` timing:** never asserted outside the cycle following a transfer (or a ZERO step).

## Timing
- **Reset values:** state IDLE, `cnt`=0, `kd_ready`=0, `write_key`=0, `key_idx`=0, `key_in`=0, `busy`=0, `done`=0, `aborted`=0.
- **Outputs:** `write_key`, `key_idx`, `key_in`, `done` and `aborted` are registered. `kd_ready` and `busy` are decoded from state.
- **Latency:**
  - `start` at cycle N → `kd_ready` high from N+1.
  - Transfer at cycle M → write at M+1.
- **Minimum load time:** KEY_WORDS+1 cycles from `start` to `done` with `kd_valid` held high.
- **Reset mid-operation:** returns to reset values immediately; any partially written key is left in the array, and the array's own reset clears it.

## Configuration
- **`SPM_KEY_ZEROIZE_EN` defined:**
  - `abort` in LOAD → ZERO.
  - ZERO writes `key_in`=0 to indices 0..KEY_WORDS-1, one per cycle, starting the cycle after `abort` is sampled.
  - `kd_ready`=0 throughout; `abort` and `start` are ignored while in ZERO.
  - After the last zero write → IDLE; `aborted` pulses in the same cycle as the last zero write.
- **`SPM_KEY_ZEROIZE_EN` undefined:** no ZERO state; abort behaves as described in Operation.

## Structure
- **Shared package:** state encoding constants (IDLE=0, LOAD=1, ZERO=2) and `KEY_WORDS` belong in the shared protected-module package/defines, next to `SECURITY`.
- **Sub-modules:** none needed. Counter, registered write port and FSM live in one module.

## Test plan
All scenarios use `SECURITY`=64 (so KEY_WORDS=4) and KEY_IDX_SIZE=2.
- Basic load: `start`, then `kd_valid` held with words 1111, 2222, 3333, 4444 → writes at idx 0..3 on four consecutive cycles, `done` with the idx 3 write, then `busy`=0.
- Back-pressure: `kd_valid` toggled 1/0 → writes only after accepted words; idx sequence 0,1,2,3 with gaps; `done` once.
- Abort without the macro: abort after two words → idx 0,1 written, `aborted` one cycle later, word 3 dropped, no further writes.
- Abort with the macro: same stimulus → zero writes at idx 0,1,2,3, `aborted` with the idx 3 zero write, `kd_ready`=0 during ZERO.
- Collisions: `start` & `abort` together → no writes, no pulses; `start` pulsed mid-LOAD → sequence unaffected.
- Reset mid-load after one word → all outputs 0 next cycle; a new `start` begins at idx 0.
